// File: rtl/ex_flow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ex_flow_ctrl_pkg
// Shared definitions for the EX-stage pipeline flow controller:
//   - fc_state_e         : FSM encoding (FC_IDLE, FC_DC_WAIT)
//   - FC_TIMEOUT_DEFAULT : default Dcache wait budget before a timeout error
//   - FC_CNT_W_DEFAULT   : default timeout counter width
// ---------------------------------------------------------------------------
package ex_flow_ctrl_pkg;

    typedef enum logic [0:0] {
        FC_IDLE    = 1'b0,
        FC_DC_WAIT = 1'b1
    } fc_state_e;

    localparam int FC_TIMEOUT_DEFAULT = 255;
    localparam int FC_CNT_W_DEFAULT   = 8;

endpackage

// File: rtl/ex_flow_ctrl_jump_buf.sv
// ---------------------------------------------------------------------------
// ex_flow_ctrl_jump_buf (fc_jump_buf)
// Holds a PC redirect while an Icache miss is outstanding and muxes the
// redirect strobe/target.
// Ports:
//   clk, rst   : core clock, synchronous active-high reset
//   br_take    : honoured branch in EX this cycle
//   br_pc      : target of that branch
//   ic_busy    : Icache miss outstanding
//   jump_flag  : PC redirect strobe
//   jump_pc    : PC redirect target (0 when jump_flag is 0)
// ---------------------------------------------------------------------------
module ex_flow_ctrl_jump_buf
    import ex_flow_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        br_take,
    input  logic [31:0] br_pc,
    input  logic        ic_busy,
    output logic        jump_flag,
    output logic [31:0] jump_pc
);

    logic        jump_pend_r;
    logic [31:0] jump_pc_r;

    // Pending-redirect storage: a fresh branch during a miss overwrites any
    // older pending target, and the pending entry retires when its strobe fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            jump_pend_r <= 1'b0;
            jump_pc_r   <= 32'h0000_0000;
        end else if (br_take && ic_busy) begin
            jump_pend_r <= 1'b1;
            jump_pc_r   <= br_pc;
        end else if (jump_pend_r && !ic_busy) begin
            jump_pend_r <= 1'b0;
            jump_pc_r   <= jump_pc_r;
        end else begin
            jump_pend_r <= jump_pend_r;
            jump_pc_r   <= jump_pc_r;
        end
    end

    // Redirect mux: a live branch beats a pending one (newest target wins).
    always_comb begin
        jump_flag = 1'b0;
        jump_pc   = 32'h0000_0000;
        if (br_take && !ic_busy) begin
            jump_flag = 1'b1;
            jump_pc   = br_pc;
        end else if (jump_pend_r && !ic_busy) begin
            jump_flag = 1'b1;
            jump_pc   = jump_pc_r;
        end else begin
            jump_flag = 1'b0;
            jump_pc   = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/ex_flow_ctrl.sv
// ---------------------------------------------------------------------------
// ex_flow_ctrl
// Pipeline flow controller for the 5-stage core. Sequences EX Dcache
// accesses (stalling IF/ID/EX/MEM while waiting), converts EX branch
// decisions into PC redirects (buffered across Icache misses) and inserts
// bubbles into IF/ID and ID/EX.
// Optional feature macro: FC_TIMEOUT_EN (Dcache wait timeout + sticky error).
// Ports:
//   clk, rst            : core clock, synchronous active-high reset
//   ex_req_Dcache_i     : EX memory request (already gated by fc_stall_ex_o)
//   ex_mem_rw_i         : request direction (status only)
//   dc_ready_i          : Dcache completion pulse
//   ex_branch_flag_i    : branch/jump taken in EX
//   ex_branch_pc_i      : redirect target
//   ic_busy_i           : Icache miss outstanding
//   fc_stall_*_o        : hold IF/ID/EX/MEM stage registers
//   fc_flush_ifid_o/idex: bubble into IF/ID, ID/EX
//   fc_jump_flag_o/pc_o : PC redirect strobe/target
//   fc_dc_busy_o        : Dcache access in flight
//   fc_dc_err_o         : sticky timeout error
// ---------------------------------------------------------------------------
module ex_flow_ctrl
    import ex_flow_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = FC_TIMEOUT_DEFAULT,
    parameter int CNT_W          = FC_CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req_Dcache_i,
    input  logic        ex_mem_rw_i,
    input  logic        dc_ready_i,
    input  logic        ex_branch_flag_i,
    input  logic [31:0] ex_branch_pc_i,
    input  logic        ic_busy_i,
    output logic        fc_stall_if_o,
    output logic        fc_stall_id_o,
    output logic        fc_stall_ex_o,
    output logic        fc_stall_mem_o,
    output logic        fc_flush_ifid_o,
    output logic        fc_flush_idex_o,
    output logic        fc_jump_flag_o,
    output logic [31:0] fc_jump_pc_o,
    output logic        fc_dc_busy_o,
    output logic        fc_dc_err_o
);

    fc_state_e state_r;
    fc_state_e next_state_s;
    logic      timeout_s;
    logic      err_s;
    logic      dc_stall_s;
    logic      dc_busy_s;
    logic      br_take_s;

    // Direction is carried for status visibility only.
    logic unused_rw_s;
    assign unused_rw_s = ex_mem_rw_i;

`ifdef FC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    // Timeout fires in a wait cycle without completion once the budget is spent.
    always_comb begin
        timeout_s = 1'b0;
        if ((state_r == FC_DC_WAIT) && !dc_ready_i && (cnt_r == TIMEOUT_LIM)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Wait counter: counts stalled wait cycles, zero outside an ongoing wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == FC_DC_WAIT) && !dc_ready_i && !timeout_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Sticky error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_s = err_r;
`else
    logic [CNT_W-1:0] unused_lim_s;
    assign unused_lim_s = CNT_W'(TIMEOUT_CYCLES);
    assign timeout_s    = 1'b0;
    assign err_s        = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FC_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state: a request in the release cycle keeps the wait state
    // so back-to-back accesses stall without an idle gap.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FC_IDLE: begin
                if (ex_req_Dcache_i) begin
                    next_state_s = FC_DC_WAIT;
                end else begin
                    next_state_s = FC_IDLE;
                end
            end
            FC_DC_WAIT: begin
                if (dc_ready_i) begin
                    next_state_s = ex_req_Dcache_i ? FC_DC_WAIT : FC_IDLE;
                end else if (timeout_s) begin
                    next_state_s = FC_IDLE;
                end else begin
                    next_state_s = FC_DC_WAIT;
                end
            end
            default: begin
                next_state_s = FC_IDLE;
            end
        endcase
    end

    // FSM outputs: stall only depends on state and completion/timeout, never
    // on the incoming request.
    always_comb begin
        dc_stall_s = 1'b0;
        dc_busy_s  = 1'b0;
        case (state_r)
            FC_IDLE: begin
                dc_stall_s = 1'b0;
                dc_busy_s  = 1'b0;
            end
            FC_DC_WAIT: begin
                dc_stall_s = !dc_ready_i && !timeout_s;
                dc_busy_s  = 1'b1;
            end
            default: begin
                dc_stall_s = 1'b0;
                dc_busy_s  = 1'b0;
            end
        endcase
    end

    // A branch in a stalled EX is re-presented later; honour it only once EX moves.
    assign br_take_s = ex_branch_flag_i && !dc_stall_s;

    assign fc_stall_if_o   = dc_stall_s || ic_busy_i;
    assign fc_stall_id_o   = dc_stall_s;
    assign fc_stall_ex_o   = dc_stall_s;
    assign fc_stall_mem_o  = dc_stall_s;
    // During a Dcache stall IF/ID must hold, so the Icache bubble is suppressed.
    assign fc_flush_ifid_o = br_take_s || (ic_busy_i && !dc_stall_s);
    assign fc_flush_idex_o = br_take_s;
    assign fc_dc_busy_o    = dc_busy_s;
    assign fc_dc_err_o     = err_s;

    ex_flow_ctrl_jump_buf u_jump_buf (
        .clk       (clk),
        .rst       (rst),
        .br_take   (br_take_s),
        .br_pc     (ex_branch_pc_i),
        .ic_busy   (ic_busy_i),
        .jump_flag (fc_jump_flag_o),
        .jump_pc   (fc_jump_pc_o)
    );

endmodule

// File: tb/tb_ex_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_flow_ctrl
// Directed bench for ex_flow_ctrl with a behavioural reference model.
// Honours FC_TIMEOUT_EN (instantiates the DUT with TIMEOUT_CYCLES = 4).
// ---------------------------------------------------------------------------
module tb_ex_flow_ctrl;

`ifdef FC_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO    = 4;
    localparam int NCYC   = 90;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, rw, ready, br, ic;
    logic [31:0] bpc;
    logic        st_if, st_id, st_ex, st_mem, fl_ifid, fl_idex, jf, busy, err;
    logic [31:0] jpc;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    // Reference model state: is an access outstanding, how many wait cycles
    // it has spent, pending redirect, sticky error.
    bit          m_waiting;
    int          m_waited;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_err;

    ex_flow_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_req_Dcache_i  (req),
        .ex_mem_rw_i      (rw),
        .dc_ready_i       (ready),
        .ex_branch_flag_i (br),
        .ex_branch_pc_i   (bpc),
        .ic_busy_i        (ic),
        .fc_stall_if_o    (st_if),
        .fc_stall_id_o    (st_id),
        .fc_stall_ex_o    (st_ex),
        .fc_stall_mem_o   (st_mem),
        .fc_flush_ifid_o  (fl_ifid),
        .fc_flush_idex_o  (fl_idex),
        .fc_jump_flag_o   (jf),
        .fc_jump_pc_o     (jpc),
        .fc_dc_busy_o     (busy),
        .fc_dc_err_o      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // Directed stimulus indexed by cycle number.
    task automatic drive(input int c);
        rst   = (c < 2) || (c == 82) || (TMO_EN && c == 68);
        req   = (c == 10) || (c == 13) || (c == 30) || (c == 50) || (c == 60) || (c == 80);
        rw    = (c == 13) || (c == 50);
        ready = (c == 13) || (c == 16) || (c == 34) || (c == 53) || (!TMO_EN && c == 71) || (c == 84);
        br    = (c == 18) || (c == 21) || (c >= 31 && c <= 34) || (c == 41) || (c == 43);
        if (c == 18)                 bpc = 32'h0000_0120;
        else if (c == 21)            bpc = 32'h0000_0200;
        else if (c >= 31 && c <= 34) bpc = 32'h0000_0340;
        else if (c == 41)            bpc = 32'h0000_0400;
        else if (c == 43)            bpc = 32'h0000_0480;
        else                         bpc = 32'h0000_0000;
        ic    = (c >= 20 && c <= 24) || (c >= 40 && c <= 44) || (c == 51) || (c == 52);
    endtask

    // Hand-computed expectations at the test-plan cycles.
    task automatic literal_checks(input int c);
        case (c)
            1:  begin chk("rst_stall_ex", st_ex, 0); chk("rst_busy", busy, 0);
                      chk("rst_jump", jf, 0); chk("rst_err", err, 0); chk("rst_flush", fl_ifid, 0); end
            10: begin chk("req_no_stall", st_ex, 0); chk("req_busy", busy, 0); end
            11: begin chk("wait_stall_mem", st_mem, 1); chk("wait_busy", busy, 1); end
            12: chk("wait_stall_if", st_if, 1);
            13: begin chk("release_stall", st_ex, 0); chk("release_busy", busy, 1); end
            14: chk("b2b_stall_id", st_id, 1);
            18: begin chk("br_jump", jf, 1); chk("br_pc", jpc, 32'h120);
                      chk("br_fl_ifid", fl_ifid, 1); chk("br_fl_idex", fl_idex, 1); end
            21: begin chk("icmiss_br_flush", fl_idex, 1); chk("icmiss_br_nojump", jf, 0); end
            24: chk("icmiss_hold", jf, 0);
            25: begin chk("pend_jump", jf, 1); chk("pend_pc", jpc, 32'h200); end
            26: begin chk("pend_once", jf, 0); chk("pend_pc_zero", jpc, 0); end
            32: begin chk("stalled_br_noflush", fl_idex, 0); chk("stalled_br_nojump", jf, 0); end
            34: begin chk("stalled_br_release", jf, 1); chk("stalled_br_pc", jpc, 32'h340); end
            35: chk("stalled_br_once", jf, 0);
            45: chk("newest_wins", jpc, 32'h480);
            51: begin chk("dstall_no_ifid_flush", fl_ifid, 0); chk("dstall_ic_stall_if", st_if, 1); end
            65: if (TMO_EN) chk("tmo_release", st_ex, 0); else chk("wait_forever", st_ex, 1);
            66: if (TMO_EN) chk("tmo_err", err, 1); else chk("wait_forever_busy", busy, 1);
            69: if (TMO_EN) chk("tmo_rst_err", err, 0); else chk("no_err", err, 0);
            70: if (!TMO_EN) chk("still_waiting", st_ex, 1); else chk("tmo_idle", busy, 0);
            71: chk("late_release", st_ex, 0);
            83: chk("rst_abandon", busy, 0);
            85: chk("late_ready_ignored", busy, 0);
            default: ;
        endcase
    endtask

    initial begin
        logic        e_dstall, e_take, e_tmo, e_jf;
        logic [31:0] e_jpc;
        m_waiting = 1'b0; m_waited = 0; m_pend = 1'b0; m_pend_pc = 32'h0; m_err = 1'b0;
        drive(0);
        @(posedge clk); #1;
        for (int c = 0; c < NCYC; c++) begin
            cyc = c;
            drive(c);
            #4;
            // Expected outputs from the current model state and inputs.
            e_tmo    = TMO_EN && m_waiting && !ready && (m_waited == TMO);
            e_dstall = m_waiting && !ready && !e_tmo;
            e_take   = br && !e_dstall;
            if (e_take && !ic)       begin e_jf = 1'b1; e_jpc = bpc;       end
            else if (m_pend && !ic)  begin e_jf = 1'b1; e_jpc = m_pend_pc; end
            else                     begin e_jf = 1'b0; e_jpc = 32'h0;     end
            if (c >= 1) begin
                chk("stall_if",   st_if,   e_dstall | ic);
                chk("stall_id",   st_id,   e_dstall);
                chk("stall_ex",   st_ex,   e_dstall);
                chk("stall_mem",  st_mem,  e_dstall);
                chk("flush_ifid", fl_ifid, e_take | (ic & !e_dstall));
                chk("flush_idex", fl_idex, e_take);
                chk("jump_flag",  jf,      e_jf);
                chk("jump_pc",    jpc,     e_jpc);
                chk("dc_busy",    busy,    m_waiting);
                chk("dc_err",     err,     m_err);
                literal_checks(c);
            end
            // Advance the model across the clock edge.
            if (rst) begin
                m_waiting = 1'b0; m_waited = 0; m_pend = 1'b0; m_pend_pc = 32'h0; m_err = 1'b0;
            end else begin
                if (e_take && ic) begin m_pend = 1'b1; m_pend_pc = bpc; end
                else if (m_pend && !ic) m_pend = 1'b0;
                if (!m_waiting) begin
                    m_waiting = req; m_waited = 0;
                end else if (ready) begin
                    m_waiting = req; m_waited = 0;
                end else if (e_tmo) begin
                    m_waiting = 1'b0; m_waited = 0; m_err = 1'b1;
                end else begin
                    m_waited++;
                end
            end
            @(posedge clk); #1;
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
